sevenseg_scan_ctl: RTL and testbench
====================================

Name: sevenseg_scan_ctl

Overview:
Time-multiplexed scan controller for a bank of NDIGITS seven-segment digits that share one seven_seg_n decoder.
- Holds one 7-bit digit code per digit, in the decoder's input format {blank, dp, dash, hex[3:0]}.
- Cycles through the digits with a prescaled ON slot, followed by an all-off guard interval against ghosting.
- Drives the shared decoder input and the active-low digit enables.

Parameters:
- NDIGITS, 8: number of multiplexed digits (2..16).
- DIV, 100000: clock cycles per digit slot, ON plus GUARD (DIV > GUARD).
- GUARD, 2: all-off cycles at the end of each slot (0 disables the guard).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: scanning enabled when high.
- wr_en, input, 1: write wr_data into the digit register at wr_addr.
- wr_addr, input, $clog2(NDIGITS): digit register index.
- wr_data, input, 7: digit code {blank, dp, dash, hex[3:0]}.
- d_out, output, 7: code to the shared decoder.
- an_n, output, NDIGITS: active-low digit enables; bit i drives digit i.
- digit_sel, output, $clog2(NDIGITS): index of the current digit.
- frame_done, output, 1: one-cycle pulse when the last digit's slot completes.

Behaviour:
- Reset (async, immediate, no clock needed):
  - all digit registers = 7'h40 (blank); state = IDLE; slot counter = 0; digit_sel = 0.
  - an_n = all ones; frame_done = 0; d_out = 7'h40.
- Registers:
  - wr_en = 1 writes reg[wr_addr] at the clock edge.
  - wr_addr >= NDIGITS is ignored.
  - A write is allowed in any state.
- d_out:
  - combinational from reg[digit_sel], so a write to the current digit appears on d_out the cycle after wr_en.
  - In IDLE, d_out = 7'h40.
- State machine (an_n, digit_sel and frame_done are registered):
  - IDLE: an_n all ones; counter = 0; digit_sel = 0. When enable = 1, go to ON at the next edge.
  - ON: an_n = ~(1 << digit_sel). The counter increments each cycle. When counter = DIV-GUARD-1: reset the counter and go to GUARD (or straight to the next digit's ON if GUARD = 0).
  - GUARD: an_n all ones; d_out still shows the current digit. When counter = GUARD-1: reset the counter, advance digit_sel, and go to ON.
- Digit advance:
  - digit_sel wraps from NDIGITS-1 to 0.
  - frame_done = 1 for exactly the one cycle in which digit_sel wraps to 0.
- enable = 0 in any non-IDLE state: at the next edge go to IDLE, with an_n all ones, digit_sel = 0 and counter = 0.
  - Re-enabling restarts at digit 0 with a full ON slot.
  - No frame_done is issued for an aborted frame.
- Simultaneous write and digit advance: the register updates and digit_sel advances in the same edge; the new digit's code is displayed.
- Counter width: $clog2(DIV); no overflow is possible.
- Per-digit timing:
  - ON length = DIV-GUARD cycles; GUARD length = GUARD cycles.
  - Frame = NDIGITS*DIV cycles.

Optional Feature:
- Macro: SEVENSEG_LZB_EN (leading-zero blanking).
- A digit is "zero" when its code = 7'h00 (hex 0, no dp, no dash, not blank).
- With the macro defined:
  - Any zero digit at an index above the highest-index non-zero digit is output on d_out as 7'h40.
  - Digit 0 is never blanked.
  - Blanking is evaluated from the current register contents each cycle.
- Without the macro: codes pass to d_out unmodified.

Test Plan:
All scenarios use NDIGITS=4, DIV=8, GUARD=2.
1. Assert rst with no clock running: an_n = 4'b1111, d_out = 7'h40, digit_sel = 0, frame_done = 0, immediately.
2. Release rst, hold enable = 1: an_n = 1110 for 6 cycles, then 1111 for 2, then 1101 for 6, and so on through 0111. frame_done pulses once every 32 cycles, as digit_sel returns to 0.
3. Write wr_addr = 2, wr_data = 7'h05 while digit 2 is ON: d_out = 7'h05 the next cycle; an_n stays 1011 and slot timing is unchanged.
4. Drop enable in the 3rd ON cycle of digit 2:
   - next cycle: an_n = 1111, digit_sel = 0, d_out = 7'h40, no frame_done.
   - re-enable: digit 0 gets a full 6-cycle ON.
5. Assert rst mid-GUARD after writing reg1 = 7'h29: outputs return to their reset values immediately. After release with enable = 1, digit 1 shows 7'h40.
6. Registers [3..0] = 7'h00, 7'h00, 7'h03, 7'h00:
   - with SEVENSEG_LZB_EN: d_out for digits 3 and 2 = 7'h40; digit 1 = 7'h03; digit 0 = 7'h00.
   - without the macro: digits 3 and 2 = 7'h00.

Source files
------------

// File: rtl/sevenseg_scan_ctl.sv
// Time-multiplexed scan controller for NDIGITS seven-segment digits sharing one decoder.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.

module sevenseg_digit_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] wd,
  output logic [6:0] code
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     code <= 7'h40;
    else if (we) code <= wd;
  end
endmodule

module sevenseg_scan_ctl #(
  parameter int NDIGITS = 8,
  parameter int DIV     = 100000,
  parameter int GUARD   = 2,
  localparam int AW     = $clog2(NDIGITS),
  localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [6:0]         wr_data,
  output logic [6:0]         d_out,
  output logic [NDIGITS-1:0] an_n,
  output logic [AW-1:0]      digit_sel,
  output logic               frame_done
);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_GUARD} state_t;

  localparam logic [CW-1:0] ON_END = CW'(DIV - GUARD - 1);
  localparam logic [CW-1:0] G_END  = CW'((GUARD > 0) ? GUARD - 1 : 0);

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [NDIGITS-1:0][6:0]   codes;

  // Out-of-range addresses match no instance, so they are dropped.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
    sevenseg_digit_reg u_reg (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_en && (wr_addr == AW'(i))),
      .wd   (wr_data),
      .code (codes[i])
    );
  end

`ifdef SEVENSEG_LZB_EN
  // upper_zero[i]: digit i and every digit above it hold a plain zero.
  logic [NDIGITS:0] upper_zero;
  assign upper_zero[NDIGITS] = 1'b1;
  for (genvar i = 0; i < NDIGITS; i++) begin : g_lzb
    assign upper_zero[i] = (codes[i] == 7'h00) && upper_zero[i+1];
  end
`endif

  always_comb begin
    d_out = 7'h40;
    if (state != S_IDLE) begin
      d_out = codes[digit_sel];
`ifdef SEVENSEG_LZB_EN
      if (digit_sel != '0 && upper_zero[digit_sel]) d_out = 7'h40;
`endif
    end
  end

  logic          wrap;
  logic [AW-1:0] nxt;
  assign wrap = (digit_sel == AW'(NDIGITS - 1));
  assign nxt  = wrap ? '0 : digit_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      digit_sel  <= '0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          digit_sel <= '0;
          an_n      <= '1;
          if (enable) begin
            state <= S_ON;
            an_n  <= ~NDIGITS'(1);
          end
        end
        S_ON: begin
          if (!enable) begin
            state     <= S_IDLE;
            cnt       <= '0;
            digit_sel <= '0;
            an_n      <= '1;
          end else if (cnt == ON_END) begin
            cnt <= '0;
            if (GUARD > 0) begin
              state <= S_GUARD;
              an_n  <= '1;
            end else begin
              digit_sel  <= nxt;
              an_n       <= ~(NDIGITS'(1) << nxt);
              frame_done <= wrap;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GUARD: begin
          if (!enable) begin
            state     <= S_IDLE;
            cnt       <= '0;
            digit_sel <= '0;
            an_n      <= '1;
          end else if (cnt == G_END) begin
            cnt        <= '0;
            state      <= S_ON;
            digit_sel  <= nxt;
            an_n       <= ~(NDIGITS'(1) << nxt);
            frame_done <= wrap;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          an_n  <= '1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Scoreboard bench for sevenseg_scan_ctl (NDIGITS=4, DIV=8, GUARD=2).
module tb_sevenseg_scan_ctl;
  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst, enable, wr_en;
  logic [1:0] wr_addr;
  logic [6:0] wr_data, d_out;
  logic [3:0] an_n;
  logic [1:0] digit_sel;
  logic       frame_done;

  sevenseg_scan_ctl #(.NDIGITS(4), .DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .d_out(d_out), .an_n(an_n), .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] dout;
    logic [1:0] sel;
    logic       fd;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         p = -1;          // cycles since the first ON cycle; -1 = idle
  logic [6:0] mem [4];

  function automatic logic [6:0] code_of(input int dg);
    logic [6:0] c;
    logic       hi_zero;
    c = mem[dg];
`ifdef SEVENSEG_LZB_EN
    hi_zero = 1'b1;
    for (int j = dg; j < 4; j++) if (mem[j] != 7'h00) hi_zero = 1'b0;
    if (dg != 0 && hi_zero) c = 7'h40;
`else
    hi_zero = 1'b0;
    if (hi_zero) c = 7'h40;
`endif
    return c;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   dg, pos;
    if (p < 0) begin
      e = '{an: 4'hF, dout: 7'h40, sel: 2'd0, fd: 1'b0};
    end else begin
      dg     = (p / 8) % 4;
      pos    = p % 8;
      e.an   = (pos < 6) ? ~(4'b0001 << dg) : 4'hF;
      e.dout = code_of(dg);
      e.sel  = 2'(dg);
      e.fd   = (p > 0) && (p % 32 == 0);
    end
    return e;
  endfunction

  task automatic do_cycle(input logic e, input logic w, input logic [1:0] a, input logic [6:0] d);
    enable = e; wr_en = w; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    if (rst) begin
      p = -1;
      for (int i = 0; i < 4; i++) mem[i] = 7'h40;
    end else begin
      if (w) mem[a] = d;
      if (p < 0) p = e ? 0 : -1;
      else       p = e ? p + 1 : -1;
    end
    q.push_back(expect_now());
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an_n"}, 16'(an_n), 16'hF);
    chk({tag, "_d_out"}, 16'(d_out), 16'h40);
    chk({tag, "_sel"}, 16'(digit_sel), 16'h0);
    chk({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  // Monitor: the DUT presents a fresh output set every cycle while the scoreboard holds entries.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({an_n, d_out, digit_sel, frame_done} !== e) begin
        bad++;
        $display("FAIL scan p=%0d: an_n=%b d_out=%h sel=%0d fd=%b want an_n=%b d_out=%h sel=%0d fd=%b",
                 p, an_n, d_out, digit_sel, frame_done, e.an, e.dout, e.sel, e.fd);
      end
    end
  end

  initial begin
    int n;
    enable = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 4; i++) mem[i] = 7'h40;
    rst = 0;
    #2 rst = 1;
    #2 chk_reset("reset_noclk");
    clk_run = 1'b1;
    do_cycle(0, 0, 0, 0);
    do_cycle(0, 0, 0, 0);
    rst = 0;

    // Free-running scan over two full frames.
    for (int i = 0; i < 70; i++) do_cycle(1, 0, 0, 0);

    // Write digit 2 at the start of its ON slot, then abort in its 3rd ON cycle.
    n = 0;
    while (p % 32 != 15 && n < 64) begin do_cycle(1, 0, 0, 0); n++; end
    chk("align_write", 16'(p % 32), 16'd15);
    do_cycle(1, 1, 2'd2, 7'h05);
    do_cycle(1, 0, 0, 0);
    do_cycle(1, 0, 0, 0);
    chk("align_abort", 16'(p % 32), 16'd18);
    do_cycle(0, 0, 0, 0);
    do_cycle(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) do_cycle(1, 0, 0, 0);

    // Reset in the middle of digit 1's guard interval.
    do_cycle(1, 1, 2'd1, 7'h29);
    n = 0;
    while (p % 32 != 14 && n < 64) begin do_cycle(1, 0, 0, 0); n++; end
    chk("align_guard", 16'(p % 32), 16'd14);
    @(negedge clk); #1;
    rst = 1;
    #1 chk_reset("reset_mid");
    do_cycle(1, 0, 0, 0);
    do_cycle(1, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 20; i++) do_cycle(1, 0, 0, 0);

    // Leading-zero pattern [3..0] = 00,00,03,00 loaded while idle.
    do_cycle(0, 1, 2'd0, 7'h00);
    do_cycle(0, 1, 2'd1, 7'h03);
    do_cycle(0, 1, 2'd2, 7'h00);
    do_cycle(0, 1, 2'd3, 7'h00);
    for (int i = 0; i < 34; i++) do_cycle(1, 0, 0, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
